// File: rtl/eq_audio_pkg.sv
// Shared audio-path types and helpers for the equalizer output stage.
package eq_audio_pkg;

   localparam int unsigned SAMPLE_W = 16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef struct packed {
      sample_t left;
      sample_t right;
   } stereo_frame_t;

   // Word-select level for a frame position: high from the last left bit
   // through the second-to-last right bit, giving the one-bclk I2S lead.
   function automatic logic lr_for_pos(input int unsigned pos, input int unsigned slot_w);
      return (pos >= slot_w - 1) && (pos <= 2 * slot_w - 2);
   endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock generator: divides clk into bclk and flags the cycle of each bclk edge.
module i2s_clk_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic bclk,
   output logic rise,
   output logic fall
);

   localparam int unsigned CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] div_cnt;
   logic             wrap;

   assign wrap = (div_cnt == CNT_LAST);
   assign rise = wrap && !bclk;
   assign fall = wrap && bclk;

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (wrap) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips-timing I2S transmitter with a single-frame holding buffer.
module i2s_tx_serializer #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned SAMPLE_W = eq_audio_pkg::SAMPLE_W,
   parameter int unsigned SLOT_W   = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic signed [SAMPLE_W-1:0] left_in,
   input  logic signed [SAMPLE_W-1:0] right_in,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       bclk,
   output logic                       lrclk,
   output logic                       sdata,
   output logic                       frame_start,
   output logic                       underrun
);

   import eq_audio_pkg::*;

   localparam int unsigned FRAME_W = 2 * SLOT_W;
   localparam int unsigned POS_W   = $clog2(FRAME_W);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_W - 1);

   typedef struct packed {
      logic [SAMPLE_W-1:0] left;
      logic [SAMPLE_W-1:0] right;
   } hold_t;

   logic               bclk_rise;
   logic               fall;
   logic [POS_W-1:0]   pos;
   logic [POS_W-1:0]   pos_next;
   logic [FRAME_W-1:0] shift_q;
   logic [SLOT_W-1:0]  left_slot;
   logic [SLOT_W-1:0]  right_slot;
   hold_t              hold;
   logic               hold_full;
   logic               accept;
   logic               load;

   i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk   (clk),
      .reset (reset),
      .bclk  (bclk),
      .rise  (bclk_rise),
      .fall  (fall)
   );

   assign pos_next   = (pos == POS_LAST) ? '0 : pos + 1'b1;
   assign load       = fall && (pos_next == '0);
   assign accept     = in_valid && !hold_full;
   assign in_ready   = !hold_full;
   assign sdata      = shift_q[FRAME_W-1];

   // Samples sit MSB-aligned in their slot; the pad below the LSB is zero.
   assign left_slot  = SLOT_W'(hold.left)  << (SLOT_W - SAMPLE_W);
   assign right_slot = SLOT_W'(hold.right) << (SLOT_W - SAMPLE_W);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos         <= POS_LAST;
         lrclk       <= 1'b0;
         shift_q     <= '0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= load;
         underrun    <= load && !hold_full;
         if (fall) begin
            pos   <= pos_next;
            lrclk <= lr_for_pos(32'(pos_next), SLOT_W);
            if (load) shift_q <= hold_full ? {left_slot, right_slot} : '0;
            else      shift_q <= shift_q << 1;
         end
      end
   end

   // NOTE: the held sample data is reset along with its full flag so a frame
   // captured before reset can never leak out afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else if (load && hold_full) begin
         hold_full <= 1'b0;
      end else if (accept) begin
         hold.left  <= left_in;
         hold.right <= right_in;
         hold_full  <= 1'b1;
      end
   end

   // The divider strobes are mutually exclusive by construction.
   a_strobes_exclusive: assert property (@(posedge clk) disable iff (reset) !(bclk_rise && fall));

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Scoreboarded bench: stimulus queues accepted frames, monitors rebuild each serial frame.
module tb_i2s_tx_serializer;

   localparam int CLK_DIV = 2;
   localparam int SLOT_A  = 16;
   localparam int SLOT_B  = 24;
   localparam int FRAME_CLKS = 2 * SLOT_A * 2 * CLK_DIV;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   // DUT A: 16-bit slots
   logic        reset, in_valid, in_ready, bclk, lrclk, sdata, frame_start, underrun;
   logic [15:0] left_in, right_in;
   // DUT B: 24-bit slots
   logic        reset_b, in_valid_b, in_ready_b, bclk_b, lrclk_b, sdata_b, frame_start_b, underrun_b;
   logic [15:0] left_in_b, right_in_b;

   i2s_tx_serializer #(.CLK_DIV(CLK_DIV), .SAMPLE_W(16), .SLOT_W(SLOT_A)) dut_a (
      .clk(clk), .reset(reset), .left_in(left_in), .right_in(right_in),
      .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk), .lrclk(lrclk),
      .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
   );

   i2s_tx_serializer #(.CLK_DIV(CLK_DIV), .SAMPLE_W(16), .SLOT_W(SLOT_B)) dut_b (
      .clk(clk), .reset(reset_b), .left_in(left_in_b), .right_in(right_in_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .bclk(bclk_b), .lrclk(lrclk_b),
      .sdata(sdata_b), .frame_start(frame_start_b), .underrun(underrun_b)
   );

   int tests = 0;
   int failed = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Reference: bit k of a frame is left MSB-first, zero pad, right MSB-first, zero pad.
   function automatic logic [63:0] exp_bits(input logic [15:0] l, input logic [15:0] r, input int slot);
      logic [63:0] v;
      logic        b;
      v = '0;
      for (int k = 0; k < 2 * slot; k++) begin
         b = 1'b0;
         if (k < 16) b = l[15-k];
         else if (k >= slot && k < slot + 16) b = r[15-(k-slot)];
         v[2*slot-1-k] = b;
      end
      return v;
   endfunction

   function automatic logic [63:0] exp_lr(input int slot);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < 2 * slot; k++)
         v[2*slot-1-k] = (k >= slot - 1) && (k <= 2 * slot - 2);
      return v;
   endfunction

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      int          acc;
   } pend_t;
   pend_t pend_q[$];

   // Monitor A state
   int          frames_seen = 0;
   int          first_rise = -1, first_fall = -1, first_load = -1, last_load = -1;
   int          last_rise = -1;
   int          bit_idx = 0;
   bit          collecting = 0;
   logic        prev_bclk = 0, prev_sdata = 0;
   logic [63:0] got_bits, got_lr, want_bits;
   int          sdata_viol = 0, period_viol = 0, und_viol = 0;

   always @(negedge clk) begin
      if (reset) begin
         collecting = 0;
         prev_bclk  = 0;
         prev_sdata = 0;
         last_rise  = -1;
         first_rise = -1;
         first_fall = -1;
         first_load = -1;
      end else begin
         if (sdata !== prev_sdata && !(prev_bclk && !bclk)) sdata_viol++;
         if (underrun && !frame_start) und_viol++;
         if (!bclk && prev_bclk && first_fall < 0) first_fall = cyc;
         if (bclk && !prev_bclk) begin
            if (last_rise >= 0 && cyc - last_rise != 2 * CLK_DIV) period_viol++;
            if (first_rise < 0) first_rise = cyc;
            last_rise = cyc;
            if (collecting) begin
               got_bits[2*SLOT_A-1-bit_idx] = sdata;
               got_lr[2*SLOT_A-1-bit_idx]   = lrclk;
               bit_idx++;
               if (bit_idx == 2 * SLOT_A) begin
                  check($sformatf("frame%0d_bits", frames_seen), got_bits, want_bits);
                  check($sformatf("frame%0d_lrclk", frames_seen), got_lr, exp_lr(SLOT_A));
                  collecting = 0;
               end
            end
         end
         if (frame_start) begin
            if (collecting) check($sformatf("frame%0d_length", frames_seen), bit_idx, 2 * SLOT_A);
            if (pend_q.size() > 0 && pend_q[0].acc < cyc) begin
               want_bits = exp_bits(pend_q[0].l, pend_q[0].r, SLOT_A);
               check($sformatf("frame%0d_underrun", frames_seen + 1), underrun, 0);
               void'(pend_q.pop_front());
            end else begin
               want_bits = '0;
               check($sformatf("frame%0d_underrun", frames_seen + 1), underrun, 1);
            end
            got_bits   = '0;
            got_lr     = '0;
            bit_idx    = 0;
            collecting = 1;
            last_load  = cyc;
            if (first_load < 0) first_load = cyc;
            frames_seen++;
         end
         prev_bclk  = bclk;
         prev_sdata = sdata;
      end
   end

   // Monitor B: checks the first 24-bit-slot frame and the lrclk period.
   int          b_rises = 0, b_last_fall_rise = -1, b_period = -1, b_idx = 0;
   bit          b_collect = 0, b_done = 0;
   logic        b_prev_bclk = 0, b_prev_lr = 0;
   logic [63:0] b_bits, b_lr;

   always @(negedge clk) begin
      if (reset_b) begin
         b_prev_bclk = 0;
         b_prev_lr   = 0;
      end else begin
         if (bclk_b && !b_prev_bclk) begin
            b_rises++;
            if (b_collect) begin
               b_bits[2*SLOT_B-1-b_idx] = sdata_b;
               b_lr[2*SLOT_B-1-b_idx]   = lrclk_b;
               b_idx++;
               if (b_idx == 2 * SLOT_B) begin
                  check("b_frame_bits", b_bits, exp_bits(16'hFFFF, 16'h0001, SLOT_B));
                  check("b_frame_lrclk", b_lr, exp_lr(SLOT_B));
                  b_collect = 0;
                  b_done    = 1;
               end
            end
         end
         if (b_prev_lr && !lrclk_b) begin
            if (b_last_fall_rise >= 0) b_period = b_rises - b_last_fall_rise;
            b_last_fall_rise = b_rises;
         end
         if (frame_start_b && !b_done && !b_collect) begin
            check("b_frame_underrun", underrun_b, 0);
            b_bits    = '0;
            b_lr      = '0;
            b_idx     = 0;
            b_collect = 1;
         end
         b_prev_bclk = bclk_b;
         b_prev_lr   = lrclk_b;
      end
   end

   task automatic wait_frames(input int n);
      int target;
      int budget;
      target = frames_seen + n;
      budget = (FRAME_CLKS + 8) * n;
      while (frames_seen < target && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (frames_seen < target) check("wait_frames_timeout", frames_seen, target);
   endtask

   // Called at a negedge; holds in_valid until the frame is accepted.
   task automatic send_a(input logic [15:0] l, input logic [15:0] r);
      int n;
      n = 0;
      left_in  = l;
      right_in = r;
      in_valid = 1'b1;
      while (!in_ready && n < 2 * FRAME_CLKS) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("send_timeout_in_ready", in_ready, 1);
      end else begin
         if (n > 0) check("in_ready_reassert_at_load", frame_start, 1);
         pend_q.push_back('{l, r, cyc + 1});
         @(negedge clk);
         check("in_ready_after_accept", in_ready, 0);
      end
      in_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bclk"}, bclk, 0);
      check({tag, "_lrclk"}, lrclk, 0);
      check({tag, "_sdata"}, sdata, 0);
      check({tag, "_frame_start"}, frame_start, 0);
      check({tag, "_underrun"}, underrun, 0);
      check({tag, "_in_ready"}, in_ready, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d frames seen", frames_seen);
      $fatal(1, "watchdog");
   end

   initial begin
      int          rel;
      int          l_cyc;
      int          budget;
      logic [15:0] rl, rr;

      reset = 1; reset_b = 1; in_valid = 0; in_valid_b = 0;
      left_in = '0; right_in = '0; left_in_b = '0; right_in_b = '0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      check("b_reset_in_ready", in_ready_b, 1);

      // Release; DUT A idles, DUT B gets its single frame before its first fall.
      @(negedge clk);
      reset = 0; reset_b = 0;
      rel = cyc;
      left_in_b = 16'hFFFF; right_in_b = 16'h0001; in_valid_b = 1;
      @(negedge clk);
      in_valid_b = 0;
      check("b_in_ready_after_accept", in_ready_b, 0);
      wait_frames(1);
      check("first_bclk_rise", first_rise, rel + CLK_DIV);
      check("first_bclk_fall", first_fall, rel + 2 * CLK_DIV);
      check("first_frame_load", first_load, rel + 2 * CLK_DIV);
      wait_frames(1);

      // Back-to-back frames with in_valid held high.
      send_a(16'h1234, 16'h5678);
      send_a(16'hABCD, 16'hEF01);
      wait_frames(3);

      // Accept on the very edge of an empty-hold load.
      l_cyc  = last_load;
      budget = 2 * FRAME_CLKS;
      while (cyc < l_cyc + FRAME_CLKS - 1 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      left_in = 16'h0F0F; right_in = 16'hC3A5; in_valid = 1;
      @(negedge clk);
      pend_q.push_back('{16'h0F0F, 16'hC3A5, cyc});
      in_valid = 0;
      check("coincide_frame_start", frame_start, 1);
      check("coincide_underrun", underrun, 1);
      check("coincide_in_ready", in_ready, 0);
      wait_frames(2);

      // Randomized frames with random gaps, some long enough to underrun.
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 300)) @(negedge clk);
         rl = 16'($urandom);
         rr = 16'($urandom);
         send_a(rl, rr);
      end
      wait_frames(3);

      // Reset in the middle of the right slot with a frame waiting in hold.
      wait_frames(1);
      l_cyc = last_load;
      send_a(16'($urandom), 16'($urandom));
      budget = 2 * FRAME_CLKS;
      while (cyc < l_cyc + 2 * CLK_DIV * (SLOT_A + 5) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      @(posedge clk);
      #3 reset = 1;
      #1;
      check_reset_outputs("midreset");
      pend_q.delete();
      repeat (2) @(negedge clk);
      reset = 0;
      rel = cyc;
      send_a(16'h8001, 16'h7FFE);
      wait_frames(2);
      check("post_reset_bclk_rise", first_rise, rel + CLK_DIV);
      check("post_reset_bclk_fall", first_fall, rel + 2 * CLK_DIV);
      check("post_reset_frame_load", first_load, rel + 2 * CLK_DIV);

      check("sdata_changes_off_fall", sdata_viol, 0);
      check("bclk_period", period_viol, 0);
      check("underrun_without_frame_start", und_viol, 0);
      check("b_frame_seen", b_done, 1);
      check("b_lrclk_period", b_period, 2 * SLOT_B);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- I2S transmitter at the output end of the audio path. Accepts filtered stereo frames from the equalizer over a valid/ready handshake. Serializes them MSB-first onto a DAC-facing I2S link.
- Generates its own bclk/lrclk from the system clock; the link runs in standard Philips I2S timing with a one-bclk data delay after lrclk changes.
- Single-frame holding buffer between the handshake and the shift register. Flags underrun when no frame is pending at a frame boundary.

Parameters:
- CLK_DIV, 4, clk cycles per bclk half-period; must be >= 1.
- SAMPLE_W, 16, sample width in bits (two's complement).
- SLOT_W, 16, bclk periods per channel slot; must be >= SAMPLE_W. Bits beyond SAMPLE_W are driven 0 after the LSB.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- left_in  in  SAMPLE_W  left sample, signed.
- right_in  in  SAMPLE_W  right sample, signed.
- in_valid  in  1  left_in/right_in hold a frame.
- in_ready  out  1  holding buffer empty; frame accepted when in_valid && in_ready.
- bclk  out  1  bit clock, registered.
- lrclk  out  1  word select, registered; 0 = left, 1 = right.
- sdata  out  1  serial data, registered; changes only with bclk falling.
- frame_start  out  1  one-clk pulse on the cycle left MSB is driven.
- underrun  out  1  one-clk pulse when a frame boundary finds the buffer empty.

Behaviour:
- Reset values (async, all outputs and state):
  - bclk=0, lrclk=0, sdata=0, frame_start=0, underrun=0, in_ready=1.
  - div_cnt=0, pos=2*SLOT_W-1, hold empty, shift register 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1. When div_cnt==CLK_DIV-1: bclk toggles and div_cnt<=0.
  - First bclk rise is registered at clk edge CLK_DIV after reset deasserts; first fall at edge 2*CLK_DIV.
  - "fall" is the internal strobe for the cycle in which bclk is updated 1->0.
- Frame position pos is 0..2*SLOT_W-1. On each fall: pos <= (pos==2*SLOT_W-1) ? 0 : pos+1.
- lrclk, updated on fall, takes the value for the new pos:
  - 1 for pos in [SLOT_W-1, 2*SLOT_W-2].
  - 0 otherwise.
  - This gives the one-bclk I2S delay: lrclk leads each channel's MSB by one bclk.
- sdata, updated on fall: the shift register MSB for the new pos. The register shifts left one bit per fall and fills with 0.
- Frame load, on the fall that enters pos=0:
  - Hold full: shift <= {left, zero pad to SLOT_W, right, zero pad to SLOT_W}; hold becomes empty; sdata = left MSB; frame_start=1 that cycle.
  - Hold empty: shift <= all zeros; sdata=0; underrun=1 and frame_start=1 that cycle.
- Holding buffer:
  - in_ready = !hold_full (registered state, no combinational path from in_valid).
  - On accept: hold <= {left_in, right_in}; hold_full <= 1.
  - Accept and load in the same cycle, hold empty: the new frame goes to hold and the current frame is zeros with underrun. No bypass.
  - Hold full: in_ready=0, so no accept can coincide with the load that drains it. in_ready returns 1 the cycle after the load.
- Throughput: one frame per 2*SLOT_W*2*CLK_DIV clk cycles (default 256). The upstream stage must deliver faster than this or underrun results.
- Reset mid-frame aborts immediately to reset values. No partial frame is resumed, and a held frame is discarded.

Decomposition:
- Package eq_audio_pkg:
  - SAMPLE_W default.
  - typedef sample_t (logic signed [SAMPLE_W-1:0]).
  - packed struct stereo_frame_t {sample_t left; sample_t right;}.
- Sub-module i2s_clk_gen, parameterized by CLK_DIV: holds div_cnt and bclk; outputs bclk plus rise/fall strobes.
- i2s_tx_serializer holds pos, lrclk, the shift register, the holding buffer and the pulses.

Test Plan:
- Reset then idle, no in_valid, CLK_DIV=2, SLOT_W=16:
  - bclk rises at edge 2 and falls at edge 4, with period 4 clks.
  - First fall: frame_start=1, underrun=1, sdata stays 0.
  - lrclk=1 for pos 15..30.
- Accept left=16'h8001, right=16'h7FFE before the first fall:
  - Left slot sdata = 1,0...0,1 MSB-first.
  - lrclk goes 1 one bclk before right MSB 0; right slot = 0,1...1,0.
  - No underrun pulse.
- Back-to-back frames with in_valid held high and distinct data (16'h1234/16'h5678 then 16'hABCD/16'hEF01):
  - in_ready deasserts after the first accept and reasserts the cycle after each load.
  - Serial stream matches both frames with no gaps or underrun.
- SLOT_W=24, SAMPLE_W=16, left=16'hFFFF, right=16'h0001:
  - Left slot is 16 ones then 8 zeros; right slot is 15 zeros, a one, then 8 zeros.
  - lrclk period is 48 bclk.
- Accept on the same clk as the pos=0 load with hold empty:
  - That frame transmits as zeros with underrun=1.
  - The accepted data appears in the following frame.
- Assert reset mid-right-slot:
  - All outputs go to reset values on the next sampling of state with no clk edge needed; hold is empty and in_ready=1.
  - After release, the first frame starts exactly 2*CLK_DIV clks later.
